// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch stage and instruction memory.
// The master issues req/addr and holds them until the slave returns valid/rdata.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           rdata;
    logic                  valid;

    modport master (
        output req,
        output addr,
        input  rdata,
        input  valid
    );

    modport slave (
        input  req,
        input  addr,
        output rdata,
        output valid
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: on each fetch_enable pulse, reads one word from imem,
// presents {pc_out, instr_out} to decode, and advances or redirects the fetch PC.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_enable,
    output logic                  fetch_done,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    fetch_unit_if.master          imem,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [31:0]           instr_out,
    output logic                  busy,
    output logic                  overlap_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  redirect_pending;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [ADDR_WIDTH-1:0] redirect_aligned;

    // Redirect targets are forced to a word boundary so pc never goes unaligned.
    assign redirect_aligned = redirect_pc & ~ADDR_WIDTH'(3);

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order within this block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            pc               <= RESET_PC;
            imem.req         <= 1'b0;
            imem.addr        <= RESET_PC;
            fetch_done       <= 1'b0;
            pc_out           <= '0;
            instr_out        <= '0;
            busy             <= 1'b0;
            overlap_err      <= 1'b0;
            redirect_pending <= 1'b0;
            redirect_target  <= RESET_PC;
        end else begin
            fetch_done <= 1'b0;

            // busy covers both WAIT and DONE, so a pulse in the DONE cycle also overlaps.
            if (fetch_enable && busy) begin
                overlap_err <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (fetch_enable) begin
                        state     <= WAIT;
                        busy      <= 1'b1;
                        imem.req  <= 1'b1;
                        imem.addr <= pc;
                        // The request already uses the old pc; the redirect waits for completion.
                        if (redirect_valid) begin
                            redirect_pending <= 1'b1;
                            redirect_target  <= redirect_aligned;
                        end
                    end else if (redirect_valid) begin
                        pc <= redirect_aligned;
                    end
                end

                WAIT: begin
                    if (imem.valid) begin
                        state            <= DONE;
                        imem.req         <= 1'b0;
                        fetch_done       <= 1'b1;
                        pc_out           <= imem.addr;
                        instr_out        <= imem.rdata;
                        redirect_pending <= 1'b0;
                        if (redirect_valid) begin
                            pc <= redirect_aligned;
                        end else if (redirect_pending) begin
                            pc <= redirect_target;
                        end else begin
                            pc <= pc + ADDR_WIDTH'(4);
                        end
                    end else if (redirect_valid) begin
                        redirect_pending <= 1'b1;
                        redirect_target  <= redirect_aligned;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (redirect_valid) begin
                        pc <= redirect_aligned;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected {addr, instr, latency, overlap}
// per fetch; a monitor pops and compares whenever fetch_done pulses.
module tb_fetch_unit;

    localparam int          AW       = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_enable = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          fetch_done;
    logic [AW-1:0] pc_out;
    logic [31:0]   instr_out;
    logic          busy;
    logic          overlap_err;

    fetch_unit_if #(.ADDR_WIDTH(AW)) imem ();

    fetch_unit #(
        .ADDR_WIDTH(AW),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_enable  (fetch_enable),
        .fetch_done    (fetch_done),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem          (imem),
        .pc_out        (pc_out),
        .instr_out     (instr_out),
        .busy          (busy),
        .overlap_err   (overlap_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents as a fixed function of address; word 0 holds a NOP-like 0x13.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        int          issue_cyc;
        int          exp_lat;
        bit          exp_ovl;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_pc  = RESET_PC;
    bit          ovl_state = 1'b0;
    int          mem_lat   = 1;

    // Memory responder: once a request is seen it answers mem_lat cycles after req rose,
    // even if the fetch unit was reset meanwhile (models an in-flight read).
    initial begin
        int          cnt      = 0;
        bit          mem_busy = 1'b0;
        logic [31:0] cap_addr = '0;
        imem.valid = 1'b0;
        imem.rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (imem.valid) begin
                imem.valid = 1'b0;
                mem_busy   = 1'b0;
                cnt        = 0;
            end else if (mem_busy || imem.req) begin
                if (!mem_busy) cap_addr = imem.addr;
                mem_busy = 1'b1;
                cnt++;
                if (cnt > mem_lat) begin
                    imem.valid = 1'b1;
                    imem.rdata = mem_word(cap_addr);
                end
            end
        end
    end

    // Monitor: request address and stability, then delivery against the scoreboard.
    initial begin
        logic        prev_req = 1'b0;
        logic [31:0] held_addr = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (imem.req && !prev_req) begin
                    held_addr = imem.addr;
                    if (sb_q.size() > 0) check("req_addr", 64'(imem.addr), 64'(sb_q[0].addr));
                end else if (imem.req && prev_req) begin
                    check("addr_stable", 64'(imem.addr), 64'(held_addr));
                end
                prev_req = imem.req;
                if (fetch_done) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 64'(fetch_done), 64'(0));
                    end else begin
                        e = sb_q.pop_front();
                        check("pc_out", 64'(pc_out), 64'(e.addr));
                        check("instr_out", 64'(instr_out), 64'(e.instr));
                        check("latency", 64'(cyc - e.issue_cyc), 64'(e.exp_lat));
                        check("overlap_at_done", 64'(overlap_err), 64'(e.exp_ovl));
                    end
                end
            end
        end
    end

    // One fetch: fetch_enable at offset 0; optional redirects / extra enables at given offsets.
    // Offsets 1..lat+1 are WAIT (valid arrives at lat+1), lat+2 is DONE.
    task automatic do_fetch(input int lat, input int r1_off, input logic [31:0] r1_pc,
                            input int r2_off, input logic [31:0] r2_pc, input int ovl_off);
        exp_t        e;
        bit          redir = 1'b0;
        logic [31:0] nxt   = '0;
        mem_lat     = lat;
        e.addr      = model_pc;
        e.instr     = mem_word(model_pc);
        e.issue_cyc = cyc;
        e.exp_lat   = lat + 2;
        e.exp_ovl   = ovl_state || (ovl_off >= 1 && ovl_off <= lat + 1);
        sb_q.push_back(e);
        for (int off = 0; off <= lat + 2; off++) begin
            fetch_enable   = (off == 0) || (off == ovl_off);
            redirect_valid = 1'b0;
            if (off == r1_off) begin
                redirect_valid = 1'b1;
                redirect_pc    = r1_pc;
                redir          = 1'b1;
                nxt            = r1_pc & ~32'd3;
            end
            if (off == r2_off) begin
                redirect_valid = 1'b1;
                redirect_pc    = r2_pc;
                redir          = 1'b1;
                nxt            = r2_pc & ~32'd3;
            end
            @(posedge clk);
            #1;
            if (off <= lat + 1) check("busy_in_fetch", 64'(busy), 64'(1));
            if (off == lat + 1) check("req_low_in_done", 64'(imem.req), 64'(0));
        end
        fetch_enable   = 1'b0;
        redirect_valid = 1'b0;
        check("idle_after_fetch", 64'({busy, imem.req}), 64'(0));
        if (ovl_off >= 1) ovl_state = 1'b1;
        model_pc = redir ? nxt : model_pc + 32'd4;
    endtask

    task automatic idle_cycle(input bit do_redir, input logic [31:0] rpc);
        redirect_valid = do_redir;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (do_redir) model_pc = rpc & ~32'd3;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        fetch_enable   = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        model_pc  = RESET_PC;
        ovl_state = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_req", 64'(imem.req), 64'(0));
        check("rst_addr", 64'(imem.addr), 64'(RESET_PC));
        check("rst_pc_out", 64'(pc_out), 64'(0));
        check("rst_instr_out", 64'(instr_out), 64'(0));
        check("rst_flags", 64'({fetch_done, busy, overlap_err}), 64'(0));

        // First fetch with two-cycle memory, then addr 4 follows.
        do_fetch(2, -1, '0, -1, '0, -1);
        do_fetch(1, -1, '0, -1, '0, -1);

        // Back-to-back single-latency fetches from reset: 0, 4, 8.
        do_reset();
        repeat (3) do_fetch(1, -1, '0, -1, '0, -1);

        // Redirect in IDLE (unaligned), then redirect during WAIT.
        idle_cycle(1'b1, 32'h0000_1002);
        do_fetch(2, 1, 32'h0000_2000, -1, '0, -1);
        // Redirect coincident with imem_valid (offset lat+1).
        do_fetch(1, 2, 32'h0000_3000, -1, '0, -1);
        // Two redirects in one WAIT: last wins.
        do_fetch(3, 1, 32'h0000_3000, 3, 32'h0000_4000, -1);
        // Redirect coincident with fetch_enable: request keeps old pc.
        do_fetch(1, 0, 32'h0000_5000, -1, '0, -1);
        // Redirect in DONE cycle.
        do_fetch(2, 4, 32'h0000_6004, -1, '0, -1);
        do_fetch(1, -1, '0, -1, '0, -1);

        // Wrap: max aligned + 4 -> 0.
        idle_cycle(1'b1, 32'hFFFF_FFFF);
        do_fetch(1, -1, '0, -1, '0, -1);
        do_fetch(1, -1, '0, -1, '0, -1);

        // Overlap during WAIT, then stickiness across a clean fetch.
        do_fetch(2, -1, '0, -1, '0, 1);
        do_fetch(1, -1, '0, -1, '0, -1);
        check("overlap_sticky", 64'(overlap_err), 64'(1));

        // fetch_enable in the DONE cycle also counts as overlap.
        do_reset();
        check("overlap_cleared", 64'(overlap_err), 64'(0));
        do_fetch(2, -1, '0, -1, '0, 4);
        check("overlap_done_cycle", 64'(overlap_err), 64'(1));

        // Reset mid-WAIT with a pending redirect and an in-flight read.
        do_reset();
        mem_lat      = 4;
        fetch_enable = 1'b1;
        @(posedge clk);
        #1;
        fetch_enable   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_7000;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        fetch_enable   = 1'b1;
        @(posedge clk);
        #1;
        fetch_enable = 1'b0;
        check("overlap_in_wait", 64'(overlap_err), 64'(1));
        check("req_held_in_wait", 64'(imem.req), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_req", 64'(imem.req), 64'(0));
        check("midrst_flags", 64'({busy, overlap_err}), 64'(0));
        check("midrst_addr", 64'(imem.addr), 64'(RESET_PC));
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("no_done_after_rst", 64'(fetch_done), 64'(0));
        end
        model_pc  = RESET_PC;
        ovl_state = 1'b0;
        do_fetch(1, -1, '0, -1, '0, -1);

        // Randomized fetch sequence.
        for (int n = 0; n < 40; n++) begin
            int lat;
            int r1;
            int r2;
            int ov;
            int gap;
            lat = int'($urandom_range(1, 4));
            r1  = ($urandom % 3 == 0) ? int'($urandom_range(0, lat + 2)) : -1;
            r2  = ($urandom % 5 == 0) ? int'($urandom_range(0, lat + 2)) : -1;
            ov  = ($urandom % 8 == 0) ? int'($urandom_range(1, lat + 2)) : -1;
            do_fetch(lat, r1, $urandom, r2, $urandom, ov);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) idle_cycle($urandom % 5 == 0, $urandom);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the multi-cycle core; sits directly upstream of decode.
- Consumes the per-step fetch_enable pulse from the stall/step controller.
- Reads one instruction word from instruction memory over a valid/request handshake and presents {pc, instruction} to decode.
- Returns a one-cycle fetch_done pulse to the controller; also maintains the architectural fetch PC, including branch/jump redirects from exec.

Parameters:
- ADDR_WIDTH, 32, width of PC and instruction-memory byte address.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_enable  input  1  one-cycle start pulse from stall controller.
- fetch_done  output  1  one-cycle pulse: fetched word captured and valid on pc_out/instr_out.
- redirect_valid  input  1  one-cycle pulse from exec: next fetch PC is redirect_pc.
- redirect_pc  input  ADDR_WIDTH  redirect target (byte address).
- imem_req  output  1  read request, held high until imem_valid.
- imem_addr  output  ADDR_WIDTH  read address, stable while imem_req high.
- imem_rdata  input  32  read data, qualified by imem_valid.
- imem_valid  input  1  read data valid; 1 or more cycles after imem_req rises.
- pc_out  output  ADDR_WIDTH  address of the last captured instruction.
- instr_out  output  32  last captured instruction word.
- busy  output  1  high while a fetch is outstanding (state WAIT or DONE).
- overlap_err  output  1  sticky: fetch_enable arrived while busy.

Behaviour:
- Reset values:
  - pc = RESET_PC
  - state IDLE
  - imem_req = 0, imem_addr = RESET_PC
  - fetch_done = 0, pc_out = 0, instr_out = 0 (a NOP is not substituted)
  - busy = 0, overlap_err = 0, redirect_pending = 0
- States: IDLE, WAIT, DONE.
- IDLE:
  - fetch_enable = 1 -> WAIT next cycle, with imem_req = 1 and imem_addr = pc.
  - imem_valid seen in IDLE is ignored.
- WAIT:
  - imem_req and imem_addr are held stable.
  - On imem_valid = 1: pc_out <= imem_addr, instr_out <= imem_rdata, imem_req <= 0, state -> DONE.
  - Next pc <= redirect target if a redirect is pending or simultaneous, else pc + 4.
- DONE:
  - fetch_done = 1 for exactly this one cycle; state -> IDLE.
  - Minimum latency is fetch_enable to fetch_done = 3 cycles when imem_valid returns one cycle after imem_req rises.
- pc_out and instr_out hold their values until the next capture. They do not change while decode is running.
- Redirect:
  - In IDLE or DONE, redirect_valid loads pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00} the next cycle.
  - In WAIT, the target is latched into redirect_pending. The outstanding read still completes and is delivered, because the controller's stall mechanism discards it. At completion, the pending target replaces pc + 4.
  - Redirect coincident with imem_valid: the redirect target wins.
  - Two redirects during one WAIT: the last one wins.
  - Redirect coincident with fetch_enable in IDLE: the request uses the old pc; the redirect is applied as pending.
- Alignment: the low 2 bits of redirect_pc are forced to 0. The pc is always word aligned.
- Arithmetic: pc + 4 wraps modulo 2^ADDR_WIDTH, so max-aligned + 4 -> 0.
- fetch_enable while busy:
  - Ignored; no second request is issued.
  - overlap_err is set to 1 and stays high until rst.
  - fetch_enable in the DONE cycle counts as busy.
- Reset mid-operation:
  - Returns to reset values next cycle and drops imem_req.
  - A late imem_valid after reset is ignored (state IDLE).
  - A pending redirect is discarded.

Test Plan:
- Reset, then fetch_enable pulse; imem_valid + rdata = 32'h0000_0013 two cycles after req -> imem_addr = 0 during req. fetch_done pulses once; pc_out = 0, instr_out = 32'h13; next request addr = 4.
- Back-to-back fetches, each with 1-cycle memory latency -> addresses 0, 4, 8. fetch_done comes exactly 3 cycles after each fetch_enable. imem_req drops between fetches.
- redirect_valid, redirect_pc = 32'h0000_1002, asserted in IDLE -> next fetch addr = 32'h1000. redirect_pc = 32'h2000 in WAIT -> current fetch delivered at old addr; following fetch addr = 32'h2000.
- Redirect to 32'h3000 in the same cycle as imem_valid -> next addr = 32'h3000, not pc + 4. Second redirect to 32'h4000 in the same WAIT after an earlier 32'h3000 -> next addr = 32'h4000.
- Redirect to 32'hFFFF_FFFC, then two fetches -> second fetch address = 32'h0000_0000.
- Extra fetch_enable during WAIT -> no new request; overlap_err = 1 and sticky. Then rst asserted during WAIT -> imem_req = 0 next cycle; late imem_valid produces no fetch_done; pc = RESET_PC.
